// File: rtl/square_wave_gen_if.sv
// Configuration channel for square_wave_gen: one offer of period/high_time/burst_n
// guarded by a valid/ready pair.
interface square_wave_gen_if #(
   parameter int CNT_W   = 32,
   parameter int BURST_W = 16
);
   // Handshake: a transfer happens on a clock edge where cfg_valid and cfg_ready are
   // both 1; the offer holds its data stable while cfg_valid waits for cfg_ready.
   logic               cfg_valid;
   logic               cfg_ready;
   logic [CNT_W-1:0]   period;
   logic [CNT_W-1:0]   high_time;
   logic [BURST_W-1:0] burst_n;

   modport master (output cfg_valid, period, high_time, burst_n, input cfg_ready);
   modport slave  (input cfg_valid, period, high_time, burst_n, output cfg_ready);
endinterface

// File: rtl/square_wave_gen.sv
// Programmable square-wave generator with continuous or burst mode; config swaps on period
// boundaries. Define SQW_COMPL_OUT_EN to add the dead-time complementary output wave_out_n.
module square_wave_gen #(
   parameter int CNT_W   = 32,
   parameter int BURST_W = 16
`ifdef SQW_COMPL_OUT_EN
   ,parameter int DEAD_T = 2
`endif
) (
   input  logic               pll_clk,
   input  logic               sys_rst_n,
   input  logic               enable,
   square_wave_gen_if.slave   cfg,
   output logic               wave_out,
`ifdef SQW_COMPL_OUT_EN
   output logic               wave_out_n,
`endif
   output logic               busy,
   output logic [BURST_W-1:0] cycle_cnt,
   output logic               done,
   output logic               cfg_loaded,
   output logic               fsm_state
);
   typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_TWO = CNT_W'(2);
   localparam logic [BURST_W:0]   B_ONE   = (BURST_W+1)'(1);

   state_t             state, state_nxt;
   logic               pend;
   logic [CNT_W-1:0]   period_p, high_p, period_a, high_a, ph;
   logic [CNT_W-1:0]   period_c, high_c;
   logic [BURST_W-1:0] burst_p, burst_a;
   logic               xfer, boundary, burst_hit, load_cfg, finish_burst, start_run;

   assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
   assign cfg.cfg_ready = ~pend;
   assign busy          = (state == RUN);
   assign fsm_state     = state;

   assign boundary  = (state == RUN) && (ph == period_a - CNT_ONE);
   assign burst_hit = (burst_a != '0) && (({1'b0, cycle_cnt} + B_ONE) == {1'b0, burst_a});

   // Clamp so the period has both a high and a low slot and ph can never run away.
   assign period_c = (period_p < CNT_TWO) ? CNT_TWO : period_p;
   assign high_c   = (high_p >= period_c) ? (period_c - CNT_ONE) : high_p;

   always_ff @(posedge pll_clk or posedge sys_rst_n) begin
      if (sys_rst_n) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      load_cfg     = 1'b0;
      finish_burst = 1'b0;
      start_run    = 1'b0;
      case (state)
         IDLE: begin
            load_cfg = pend;
            // Start decision sees a config being copied in this same cycle.
            if (enable && (cfg_loaded || pend)) begin
               state_nxt = RUN;
               start_run = 1'b1;
            end
         end
         RUN: begin
            if (boundary) begin
               if (burst_hit) begin
                  finish_burst = 1'b1;
                  state_nxt    = IDLE;
               end else if (!enable) begin
                  state_nxt = IDLE;
               end else begin
                  load_cfg = pend;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pll_clk or posedge sys_rst_n) begin
      if (sys_rst_n) begin
         pend       <= 1'b0;
         period_p   <= '0;
         high_p     <= '0;
         burst_p    <= '0;
         period_a   <= '0;
         high_a     <= '0;
         burst_a    <= '0;
         cfg_loaded <= 1'b0;
         ph         <= '0;
         cycle_cnt  <= '0;
         done       <= 1'b0;
         wave_out   <= 1'b0;
      end else begin
         done <= finish_burst;
         if (xfer) begin
            pend     <= 1'b1;
            period_p <= cfg.period;
            high_p   <= cfg.high_time;
            burst_p  <= cfg.burst_n;
         end
         if (load_cfg) begin
            pend       <= 1'b0;
            period_a   <= period_c;
            high_a     <= high_c;
            burst_a    <= burst_p;
            cfg_loaded <= 1'b1;
         end
         if (state == RUN && state_nxt == RUN) ph <= boundary ? '0 : ph + CNT_ONE;
         else                                  ph <= '0;
         if (start_run)                          cycle_cnt <= '0;
         else if (boundary && cycle_cnt != '1)   cycle_cnt <= cycle_cnt + 1'b1;
         // Output trails ph by one cycle, so a period swap never clips the high phase.
         wave_out <= (state == RUN) && (ph < high_a);
      end
   end

`ifdef SQW_COMPL_OUT_EN
   localparam logic [CNT_W:0] DT = (CNT_W+1)'(DEAD_T);

   // High only inside the low phase of wave_out, shrunk by DEAD_T on both sides.
   always_ff @(posedge pll_clk or posedge sys_rst_n) begin
      if (sys_rst_n) wave_out_n <= 1'b0;
      else           wave_out_n <= (state == RUN) &&
                                   ({1'b0, ph} >= ({1'b0, high_a} + DT)) &&
                                   (({1'b0, ph} + DT) < {1'b0, period_a});
   end
`endif
endmodule

// File: tb/tb_square_wave_gen.sv
// Directed bench for square_wave_gen: latency, continuous, burst, reconfig, clamping,
// enable drop and mid-period reset, plus the complementary output when it is built in.
module tb_square_wave_gen;
   logic        pll_clk = 1'b0;
   logic        sys_rst_n;
   logic        enable;
   logic        wave_out;
   logic        busy;
   logic [15:0] cycle_cnt;
   logic        done;
   logic        cfg_loaded;
   logic        fsm_state;
`ifdef SQW_COMPL_OUT_EN
   logic        wave_out_n;
`endif
   int          total = 0;
   int          bad   = 0;

   square_wave_gen_if #(.CNT_W(32), .BURST_W(16)) cfg_if ();

   square_wave_gen #(.CNT_W(32), .BURST_W(16)) dut (
      .pll_clk    (pll_clk),
      .sys_rst_n  (sys_rst_n),
      .enable     (enable),
      .cfg        (cfg_if),
      .wave_out   (wave_out),
`ifdef SQW_COMPL_OUT_EN
      .wave_out_n (wave_out_n),
`endif
      .busy       (busy),
      .cycle_cnt  (cycle_cnt),
      .done       (done),
      .cfg_loaded (cfg_loaded),
      .fsm_state  (fsm_state)
   );

   always #5 pll_clk = ~pll_clk;

   task automatic tick();
      @(posedge pll_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write a config while stopped and let it settle into the active registers.
   task automatic load(input int p, input int h, input int b);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.period    = p;
      cfg_if.high_time = h;
      cfg_if.burst_n   = 16'(b);
      chk("load_ready_before", cfg_if.cfg_ready, 1);
      tick();
      cfg_if.cfg_valid = 1'b0;
      chk("load_ready_pending", cfg_if.cfg_ready, 0);
      tick();
      chk("load_ready_after", cfg_if.cfg_ready, 1);
      chk("load_cfg_loaded", cfg_loaded, 1);
   endtask

   task automatic start();
      enable = 1'b1;
      tick();
      chk("start_busy", busy, 1);
      chk("start_cycle_cnt", cycle_cnt, 0);
   endtask

   // Drop enable and count cycles until the generator leaves RUN.
   task automatic stop_run(input string tag, input int exp_n, input int exp_highs);
      int n = 0;
      int highs = 0;
      int seen_done = 0;
      enable = 1'b0;
      while (busy && n < 100) begin
         tick();
         n++;
         if (wave_out) highs++;
         if (done) seen_done = 1;
      end
      chk({tag, "_stop_cycles"}, n, exp_n);
      chk({tag, "_stop_highs"}, highs, exp_highs);
      chk({tag, "_stop_no_done"}, seen_done, 0);
      tick();
      chk({tag, "_idle_wave"}, wave_out, 0);
   endtask

   initial begin
      sys_rst_n        = 1'b1;
      enable           = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.period    = '0;
      cfg_if.high_time = '0;
      cfg_if.burst_n   = '0;
      tick();
      tick();
      sys_rst_n = 1'b0;
      tick();
      chk("rst_wave", wave_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_cfg_ready", cfg_if.cfg_ready, 1);
      chk("rst_cfg_loaded", cfg_loaded, 0);
      chk("rst_state", fsm_state, 0);

      // period 4 / high 1 continuous, transfer with enable already high
      enable           = 1'b1;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.period    = 4;
      cfg_if.high_time = 1;
      cfg_if.burst_n   = 0;
      tick();
      cfg_if.cfg_valid = 1'b0;
      chk("lat_t0_busy", busy, 0);
      chk("lat_t0_ready", cfg_if.cfg_ready, 0);
      tick();
      chk("lat_t1_loaded", cfg_loaded, 1);
      chk("lat_t1_busy", busy, 1);
      chk("lat_t1_wave", wave_out, 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("cont_wave", wave_out, (k % 4 == 0) ? 1 : 0);
         chk("cont_cycle_cnt", cycle_cnt, (k + 1) / 4);
         chk("cont_busy", busy, 1);
      end
      stop_run("cont", 4, 1);

      // burst of three 10/3 periods; enable dropped late must not cut the burst
      load(10, 3, 3);
      start();
      for (int s = 1; s <= 30; s++) begin
         tick();
         chk("burst_wave", wave_out, (((s - 1) % 10) < 3) ? 1 : 0);
         if (s < 30) chk("burst_no_done", done, 0);
         if (s == 25) enable = 1'b0;
      end
      chk("burst_done", done, 1);
      chk("burst_busy_end", busy, 0);
      chk("burst_cycle_cnt", cycle_cnt, 3);
      tick();
      chk("burst_done_single", done, 0);
      chk("burst_wave_after", wave_out, 0);
      chk("burst_busy_after", busy, 0);

      // 8/4 running, 6/2 offered mid-period, takes over at the next boundary
      load(8, 4, 0);
      start();
      for (int s = 1; s <= 24; s++) begin
         tick();
         chk("recfg_wave", wave_out,
             (s <= 16) ? ((((s - 1) % 8) < 4) ? 1 : 0) : ((((s - 17) % 6) < 2) ? 1 : 0));
         if (s == 10) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.period    = 6;
            cfg_if.high_time = 2;
            cfg_if.burst_n   = 0;
         end
         if (s == 11) begin
            cfg_if.cfg_valid = 1'b0;
            chk("recfg_pending", cfg_if.cfg_ready, 0);
         end
         if (s == 16) chk("recfg_applied", cfg_if.cfg_ready, 1);
      end
      stop_run("recfg", 4, 0);

      // clamping: period 1 / high 5 becomes 2 / 1
      load(1, 5, 0);
      start();
      for (int s = 1; s <= 6; s++) begin
         tick();
         chk("clamp_wave", wave_out, (((s - 1) % 2) == 0) ? 1 : 0);
      end
      chk("clamp_cycle_cnt", cycle_cnt, 3);
      stop_run("clamp", 2, 1);

      // high_time 0: constant low, periods still counted
      load(5, 0, 0);
      start();
      for (int s = 1; s <= 15; s++) begin
         tick();
         chk("zero_high_wave", wave_out, 0);
      end
      chk("zero_high_cycle_cnt", cycle_cnt, 3);
      stop_run("zero_high", 5, 0);

      // enable dropped at ph 2 of 10/5: the period completes without a runt
      load(10, 5, 0);
      start();
      tick();
      tick();
      stop_run("drop", 8, 3);

      // reset asserted in the middle of the high phase with a config pending
      load(10, 5, 0);
      start();
      tick();
      chk("rst_mid_wave_s1", wave_out, 1);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.period    = 7;
      cfg_if.high_time = 3;
      tick();
      cfg_if.cfg_valid = 1'b0;
      chk("rst_mid_wave_s2", wave_out, 1);
      chk("rst_mid_pending", cfg_if.cfg_ready, 0);
      #1;
      sys_rst_n = 1'b1;
      #1;
      chk("rst_mid_wave", wave_out, 0);
      chk("rst_mid_ready", cfg_if.cfg_ready, 1);
      chk("rst_mid_loaded", cfg_loaded, 0);
      chk("rst_mid_busy", busy, 0);
      tick();
      sys_rst_n = 1'b0;
      tick();
      chk("rst_mid_stays_idle", busy, 0);

`ifdef SQW_COMPL_OUT_EN
      load(20, 8, 0);
      start();
      for (int s = 1; s <= 40; s++) begin
         tick();
         chk("compl_wave", wave_out, (((s - 1) % 20) < 8) ? 1 : 0);
         chk("compl_wave_n", wave_out_n,
             ((((s - 1) % 20) >= 10) && (((s - 1) % 20) < 18)) ? 1 : 0);
         chk("compl_overlap", wave_out & wave_out_n, 0);
      end
      stop_run("compl", 20, 8);
      chk("compl_idle_n", wave_out_n, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/square_wave_gen.md
Name: square_wave_gen

Overview:
- Programmable square-wave transmitter clocked by pll_clk (200 MHz, 5 ns resolution).
- Period and high time are set in pll_clk cycles. Supports continuous output or a burst of N periods.
- It is the stimulus source for the frequency/duty measurement path: its output loops back into the measurement block's wave input for self-test, or drives an external pin.
- Configuration changes are glitch-free and take effect only on period boundaries.

Parameters:
- CNT_W, 32, width of the period and high_time counters and registers.
- BURST_W, 16, width of burst_n and cycle_cnt.

Ports:
- pll_clk  in  1  generator clock, 200 MHz.
- sys_rst_n  in  1  reset, asynchronous, active-high.
- enable  in  1  level; 1 = run, 0 = stop at the end of the current period.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  configuration accept; a transfer occurs when cfg_valid and cfg_ready are both 1 on a pll_clk edge.
- period  in  CNT_W  period in pll_clk cycles; sampled on transfer.
- high_time  in  CNT_W  high time in pll_clk cycles; sampled on transfer.
- burst_n  in  BURST_W  number of periods per burst; 0 = continuous; sampled on transfer.
- wave_out  out  1  registered square-wave output.
- busy  out  1  1 while the FSM is in RUN.
- cycle_cnt  out  BURST_W  number of periods completed in the current run.
- done  out  1  single-cycle pulse when a burst completes.

Behaviour:
- Reset:
  - sys_rst_n=1 asynchronously clears all state: FSM to IDLE, wave_out=0, busy=0, done=0, cycle_cnt=0, cfg_ready=1.
  - Pending and active configuration are cleared, and cfg_loaded=0.
  - Reset asserted mid-period forces wave_out=0 immediately; no completion of the current period.
- Configuration path:
  - A transfer writes the pending registers and sets pend=1. cfg_ready = ~pend.
  - In IDLE, pending is copied to active on the next cycle: pend cleared, cfg_loaded set.
  - In RUN, pending is copied to active only at a period boundary, i.e. the cycle where ph == period_a-1.
- Clamping is applied when copying pending to active:
  - period<2 → 2.
  - high_time>=period → period-1.
  - high_time=0 is legal and gives constant low with periods still counted.
- FSM states:
  - IDLE: wave_out=0, busy=0, ph=0. Go to RUN when enable=1 and cfg_loaded=1, evaluated after any same-cycle pending→active copy. On entry cycle_cnt=0.
  - RUN: ph increments each cycle, 0..period_a-1, then wraps to 0.
    - wave_out register <= (ph_next < high_a), so wave_out is high for exactly high_a cycles per period, starting the cycle after entering RUN.
  - Boundary, at ph == period_a-1:
    - cycle_cnt += 1, saturating at all-ones.
    - If burst_a != 0 and cycle_cnt+1 == burst_a: done=1 for one cycle, go to IDLE.
    - Else if enable=0: go to IDLE with no done pulse.
    - Else: stay in RUN, apply pending config if present; the new period starts with the new values.
- Latency: cfg transfer at cycle t in IDLE with enable=1:
  - Active config loaded at t+1.
  - RUN entered at t+2.
  - First wave_out=1 at t+3.
- enable dropping mid-period never produces a runt pulse; the current period completes.
- Simultaneous events:
  - A transfer in the same cycle as a boundary is not applied at that boundary; it applies at the next one.
  - A burst ending and a pending config at the same boundary: go to IDLE, then pending is loaded in IDLE.
- Wrap-around: ph never exceeds period_a-1. No 2^CNT_W overflow is possible, since period_a ≤ 2^CNT_W-1.
- Output frequency = 200 MHz / period_a; duty = high_a / period_a.

Optional Feature:
- SQW_COMPL_OUT_EN defined:
  - Adds port wave_out_n (out, 1) and parameter DEAD_T (default 2).
  - wave_out_n is the registered complement of wave_out with DEAD_T cycles of both-low at each edge, so wave_out and wave_out_n are never 1 in the same cycle.
  - If high_a or period_a-high_a ≤ 2*DEAD_T, the affected phase of wave_out_n stays low.
  - Reset value 0; 0 in IDLE.
- Not defined: no wave_out_n port and no dead-time logic; wave_out is unchanged.

Test Plan:
- Reset, then cfg period=4 high_time=1 burst_n=0 with enable=1 → wave_out pattern 1000 repeating; first 1 at t+3; busy=1; cycle_cnt increments every 4 cycles.
- period=10 high_time=3 burst_n=3 → exactly three pulses of 3 cycles each; done pulses once on the cycle after the 30th RUN cycle; busy=0 after; wave_out stays 0.
- While running period=8 high=4, transfer period=6 high=2 mid-period → current period finishes as 4H/4L, next period is 2H/4L; no runt.
- Clamping: period=1 high_time=5 → period_a=2, high_a=1, output alternates 1,0. Separately, high_time=0 period=5 → wave_out constant 0 while cycle_cnt increments every 5 cycles.
- Drop enable at ph=2 of period=10 high=5 → period completes, IDLE at boundary, done stays 0. Assert sys_rst_n mid-high → wave_out=0 immediately, cfg_ready=1, cfg_loaded=0.
- SQW_COMPL_OUT_EN with DEAD_T=2, period=20, high=8 → wave_out_n high for 8 cycles per period; at least 2 cycles of both-low on each side; never both high.
